// File: rtl/mips_core_pkg.sv
// Shared types and sizing for the physical-register allocator.
// Free map bit i = 1 means physical register i is free.
package mips_core_pkg;

  localparam int NUM_PREGS = 64;
  localparam int NUM_AREGS = 32;
  localparam int NUM_CKPT  = 4;
  localparam int NUM_REL   = 2;
  localparam int PW        = $clog2(NUM_PREGS);
  localparam int CW        = $clog2(NUM_CKPT);

  typedef logic [PW-1:0]        preg_t;
  typedef logic [CW-1:0]        ckpt_id_t;
  typedef logic [NUM_PREGS-1:0] free_map_t;

  function automatic free_map_t reset_map();
    free_map_t m;
    for (int i = 0; i < NUM_PREGS; i++) begin
      m[i] = (i >= NUM_AREGS);
    end
    return m;
  endfunction

  localparam free_map_t RESET_MAP = reset_map();

  function automatic logic [PW:0] popcnt(free_map_t m);
    logic [PW:0] c;
    c = '0;
    for (int i = 0; i < NUM_PREGS; i++) begin
      c = c + {{PW{1'b0}}, m[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/preg_alloc_ctrl_prio_enc.sv
// Find-first-set over the free map: lowest free preg index plus valid.
// Index is zero when no bit is set.
module preg_prio_enc
  import mips_core_pkg::*;
(
  input  logic [NUM_PREGS-1:0] map_i,
  output logic [PW-1:0]        idx_o,
  output logic                 vld_o
);

  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = NUM_PREGS - 1; i >= 0; i--) begin
      if (map_i[i]) begin
        idx_o = preg_t'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/preg_alloc_ctrl.sv
// Physical-register free list with branch checkpoint stack.
// Optional PREG_DBL_FREE_CHECK_EN builds the sticky double-free detector.
module preg_alloc_ctrl
  import mips_core_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alloc_req,
  output logic                  alloc_gnt,
  output logic [PW-1:0]         alloc_preg,
  input  logic [NUM_REL-1:0]    rel_valid,
  input  logic [NUM_REL*PW-1:0] rel_preg,
  input  logic                  ckpt_req,
  output logic                  ckpt_ready,
  output logic [CW-1:0]         ckpt_id,
  input  logic                  ckpt_commit,
  input  logic                  restore_req,
  input  logic [CW-1:0]         restore_id,
  output logic [PW:0]           free_count,
  output logic                  err_dbl_free
);

  free_map_t   map_q, map_d;
  logic [PW:0] cnt_q, cnt_d;
  free_map_t   slot_q [NUM_CKPT];
  free_map_t   slot_d [NUM_CKPT];
  ckpt_id_t    head_q, head_d;
  ckpt_id_t    tail_q, tail_d;
  logic [CW:0] live_q, live_d;

  preg_t     enc_idx;
  logic      enc_vld;
  free_map_t rel_mask;
  free_map_t gnt_mask;
  free_map_t kept;
  ckpt_id_t  rst_off;
  logic      rst_ok;
  logic      commit_ok;
  logic      ckpt_ok;

  preg_prio_enc u_enc (
    .map_i (map_q),
    .idx_o (enc_idx),
    .vld_o (enc_vld)
  );

  assign alloc_gnt  = alloc_req && enc_vld && !restore_req;
  assign alloc_preg = enc_idx;
  assign ckpt_ready = live_q < (CW+1)'(NUM_CKPT);
  assign ckpt_id    = tail_q;
  assign free_count = cnt_q;

  // Preg 0 is hard-wired allocated, so its release is dropped here.
  always_comb begin
    rel_mask = '0;
    for (int p = 0; p < NUM_REL; p++) begin
      if (rel_valid[p] && rel_preg[p*PW +: PW] != '0) begin
        rel_mask[rel_preg[p*PW +: PW]] = 1'b1;
      end
    end
  end

  assign gnt_mask  = alloc_gnt ? (free_map_t'(1) << enc_idx) : '0;
  assign kept      = map_q & ~gnt_mask;
  assign rst_off   = restore_id - head_q;
  assign rst_ok    = restore_req && ({1'b0, rst_off} < live_q);
  assign commit_ok = ckpt_commit && (live_q != '0);
  assign ckpt_ok   = ckpt_req && ckpt_ready && !restore_req;

  always_comb begin
    map_d  = kept | rel_mask;
    cnt_d  = cnt_q - {{PW{1'b0}}, alloc_gnt}
           + popcnt(rel_mask & ~kept);
    head_d = head_q;
    tail_d = tail_q;
    live_d = live_q;
    for (int i = 0; i < NUM_CKPT; i++) begin
      slot_d[i] = slot_q[i] | rel_mask;
    end
    if (rst_ok) begin
      map_d  = slot_q[restore_id] | rel_mask;
      cnt_d  = popcnt(map_d);
      tail_d = restore_id;
      live_d = {1'b0, rst_off};
      // Commit pops head only if the restore left an older slot alive.
      if (ckpt_commit && rst_off != '0) begin
        head_d = head_q + 1'b1;
        live_d = {1'b0, rst_off} - 1'b1;
      end
    end else begin
      if (commit_ok) begin
        head_d = head_q + 1'b1;
      end
      if (ckpt_ok) begin
        slot_d[tail_q] = map_d;
        tail_d         = tail_q + 1'b1;
      end
      live_d = live_q + {{CW{1'b0}}, ckpt_ok}
             - {{CW{1'b0}}, commit_ok};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map_q  <= RESET_MAP;
      cnt_q  <= (PW+1)'(NUM_PREGS - NUM_AREGS);
      head_q <= '0;
      tail_q <= '0;
      live_q <= '0;
      for (int i = 0; i < NUM_CKPT; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      map_q  <= map_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
      live_q <= live_d;
      for (int i = 0; i < NUM_CKPT; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

`ifdef PREG_DBL_FREE_CHECK_EN
  logic err_q, err_d;
  logic dbl;

  always_comb begin
    dbl = 1'b0;
    for (int p = 0; p < NUM_REL; p++) begin
      if (rel_valid[p] && rel_preg[p*PW +: PW] != '0
          && map_q[rel_preg[p*PW +: PW]]) begin
        dbl = 1'b1;
      end
    end
    err_d = err_q | dbl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_dbl_free = err_q;
`else
  assign err_dbl_free = 1'b0;
`endif

endmodule
